instr_fetch_sequencer: RTL and testbench

Front end of the 16-bit multi-cycle datapath, feeding the 4-bit opcode decoder.
- Fetches one 16-bit instruction per step from instruction memory through a req/ack handshake.
- Latches the instruction into the instruction register and presents opcode = instr[15:12] to the decoder, holding it until the datapath accepts it.
- Takes PC redirects from branch, cal and ret resolution.
- Halts on the unused opcode.

---
 rtl/instr_fetch_sequencer_if.sv | 27 ++
 rtl/instr_fetch_sequencer.sv | 110 +++++++++++
 tb/tb_instr_fetch_sequencer.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_sequencer_if.sv
// Instruction fetch sequencer bus bundle.
// Groups the instruction-memory read handshake and the decoder/datapath
// issue handshake, including PC redirects from branch/cal/ret resolution.
//   master : the fetch sequencer (drives mem_req/mem_addr and instr/opcode/opcode_valid)
//   slave  : memory plus datapath side (drives mem_rdata/mem_ack, issue_ack, redirect_*)
interface instr_fetch_sequencer_if;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic [15:0] instr;
    logic [3:0]  opcode;
    logic        opcode_valid;
    logic        issue_ack;
    logic        redirect_valid;
    logic [15:0] redirect_pc;

    modport master (
        output mem_req, mem_addr, instr, opcode, opcode_valid,
        input  mem_rdata, mem_ack, issue_ack, redirect_valid, redirect_pc
    );

    modport slave (
        input  mem_req, mem_addr, instr, opcode, opcode_valid,
        output mem_rdata, mem_ack, issue_ack, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/instr_fetch_sequencer.sv
// Instruction fetch sequencer: front end of the 16-bit multi-cycle datapath.
// Fetches one instruction per step over a req/ack memory handshake, holds it
// in the instruction register for the opcode decoder until the datapath
// consumes it, then advances the PC sequentially or to a redirect target.
// Fetching the halt opcode parks the sequencer until reset.
// Ports:
//   clk         : system clock, all state updates on posedge
//   reset       : synchronous active-high reset
//   bus         : memory read and issue/redirect handshakes (master side)
//   pc          : address of the instruction held in the instruction register
//   pc_next_seq : pc + PC_STEP (wrapping), the cal return address
//   halted      : sequencer stopped on HALT_OP
//   instr_count : number of instructions issued (wraps)
module instr_fetch_sequencer #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] PC_STEP  = 16'h0002,
    parameter logic [3:0]  HALT_OP  = 4'h9
) (
    input  logic                          clk,
    input  logic                          reset,
    instr_fetch_sequencer_if.master       bus,
    output logic [15:0]                   pc,
    output logic [15:0]                   pc_next_seq,
    output logic                          halted,
    output logic [15:0]                   instr_count
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] ISSUE = 2'd2;
    localparam logic [1:0] HALT  = 2'd3;

    logic [1:0]  stateR;
    logic        memReqR;
    logic        opcodeValidR;
    logic        haltedR;
    logic [15:0] instrR;
    logic [15:0] pcR;
    logic [15:0] instrCountR;
    logic [15:0] pcNextSeqS;

    // Sequential successor of the current PC; 16-bit add wraps naturally.
    assign pcNextSeqS = pcR + PC_STEP;

    // FSM and all architectural registers. mem_req and opcode_valid are kept
    // as registers updated on the same edge as the state, so they can never
    // be high together and carry no decode glitches.
    always_ff @(posedge clk) begin
        if (reset) begin
            stateR       <= IDLE;
            memReqR      <= 1'b0;
            opcodeValidR <= 1'b0;
            haltedR      <= 1'b0;
            instrR       <= 16'h0000;
            pcR          <= RESET_PC;
            instrCountR  <= 16'h0000;
        end else begin
            case (stateR)
                IDLE: begin
                    stateR  <= FETCH;
                    memReqR <= 1'b1;
                end
                FETCH: begin
                    if (bus.mem_ack) begin
                        instrR  <= bus.mem_rdata;
                        memReqR <= 1'b0;
                        if (bus.mem_rdata[15:12] == HALT_OP) begin
                            stateR  <= HALT;
                            haltedR <= 1'b1;
                        end else begin
                            stateR       <= ISSUE;
                            opcodeValidR <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    // redirect_valid only matters in the cycle the datapath accepts
                    if (bus.issue_ack) begin
                        instrCountR  <= instrCountR + 16'h0001;
                        pcR          <= bus.redirect_valid ? bus.redirect_pc : pcNextSeqS;
                        opcodeValidR <= 1'b0;
                        memReqR      <= 1'b1;
                        stateR       <= FETCH;
                    end
                end
                HALT: begin
                    stateR <= HALT;
                end
                default: begin
                    // Unreachable encoding: park safely with nothing asserted.
                    stateR       <= HALT;
                    memReqR      <= 1'b0;
                    opcodeValidR <= 1'b0;
                    haltedR      <= 1'b1;
                end
            endcase
        end
    end

    assign bus.mem_req      = memReqR;
    assign bus.mem_addr     = pcR;
    assign bus.instr        = instrR;
    assign bus.opcode       = instrR[15:12];
    assign bus.opcode_valid = opcodeValidR;
    assign pc               = pcR;
    assign pc_next_seq      = pcNextSeqS;
    assign halted           = haltedR;
    assign instr_count      = instrCountR;

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
module tb_instr_fetch_sequencer;

    localparam logic [15:0] RESET_PC = 16'h0000;
    localparam logic [15:0] PC_STEP  = 16'h0002;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] pc;
    logic [15:0] pcNextSeq;
    logic        halted;
    logic [15:0] instrCount;

    int          testsRun = 0;
    int          failCount = 0;

    // Reference model state: where the next fetch must happen and how many
    // instructions must have been issued so far.
    logic [15:0] expPc;
    logic [15:0] expCount;
    logic [15:0] memory [logic [15:0]];

    instr_fetch_sequencer_if bus();

    instr_fetch_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .pc          (pc),
        .pc_next_seq (pcNextSeq),
        .halted      (halted),
        .instr_count (instrCount)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            failCount++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Memory contents are created lazily; random words never carry the halt opcode.
    function automatic logic [15:0] getWord(input logic [15:0] addr);
        logic [15:0] w;
        if (!memory.exists(addr)) begin
            w = 16'($urandom);
            if (w[15:12] == 4'h9) w[15:12] = 4'h1;
            memory[addr] = w;
        end
        return memory[addr];
    endfunction

    task automatic idleInputs();
        bus.mem_rdata      = 16'h0000;
        bus.mem_ack        = 1'b0;
        bus.issue_ack      = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 16'h0000;
    endtask

    // Caller sets any stimulus for the reset cycle beforehand.
    task automatic doReset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_mem_req", bus.mem_req, 16'h0000);
        check("rst_mem_addr", bus.mem_addr, RESET_PC);
        check("rst_instr", bus.instr, 16'h0000);
        check("rst_opcode", bus.opcode, 16'h0000);
        check("rst_opcode_valid", bus.opcode_valid, 16'h0000);
        check("rst_pc", pc, RESET_PC);
        check("rst_halted", halted, 16'h0000);
        check("rst_count", instrCount, 16'h0000);
        // Idle cycle: stray handshakes must be ignored.
        bus.mem_ack        = 1'b1;
        bus.mem_rdata      = 16'($urandom);
        bus.issue_ack      = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 16'($urandom);
        tick();
        idleInputs();
        expPc    = RESET_PC;
        expCount = 16'h0000;
    endtask

    task automatic checkFetch();
        check("fetch_mem_req", bus.mem_req, 16'h0001);
        check("fetch_mem_addr", bus.mem_addr, expPc);
        check("fetch_opcode_valid", bus.opcode_valid, 16'h0000);
        check("fetch_pc", pc, expPc);
        check("fetch_halted", halted, 16'h0000);
        check("fetch_count", instrCount, expCount);
    endtask

    // Fetch with 'waits' wait states; optionally reset lands in the ack cycle.
    task automatic fetchPhase(input int waits, input logic [15:0] word, input logic withReset);
        logic last;
        for (int w = 0; w <= waits; w++) begin
            checkFetch();
            last               = (w == waits);
            bus.mem_ack        = last;
            bus.mem_rdata      = last ? word : 16'($urandom);
            bus.redirect_valid = 1'($urandom_range(0, 1));
            bus.redirect_pc    = 16'($urandom);
            bus.issue_ack      = 1'b0;
            if (last && withReset) doReset();
            else tick();
        end
        bus.mem_ack = 1'b0;
    endtask

    // One instruction: fetch, hold in issue for 'stalls' extra cycles, then
    // accept. abortAt=1 resets in the mem_ack cycle, 2 in the issue_ack cycle.
    task automatic runInstr(input int waits, input int stalls, input logic redir,
                            input logic [15:0] target, input int abortAt);
        logic [15:0] word;
        logic        last;
        word = getWord(expPc);
        fetchPhase(waits, word, abortAt == 1);
        if (abortAt != 1) begin
            for (int s = 0; s <= stalls; s++) begin
                check("issue_opcode_valid", bus.opcode_valid, 16'h0001);
                check("issue_mem_req", bus.mem_req, 16'h0000);
                check("issue_instr", bus.instr, word);
                check("issue_opcode", bus.opcode, {12'h000, word[15:12]});
                check("issue_pc", pc, expPc);
                check("issue_pc_next_seq", pcNextSeq, expPc + PC_STEP);
                check("issue_count", instrCount, expCount);
                check("issue_halted", halted, 16'h0000);
                last               = (s == stalls);
                bus.issue_ack      = last;
                bus.redirect_valid = last ? redir : 1'($urandom_range(0, 1));
                bus.redirect_pc    = last ? target : 16'($urandom);
                bus.mem_ack        = 1'($urandom_range(0, 1));
                bus.mem_rdata      = 16'($urandom);
                if (last && abortAt == 2) doReset();
                else tick();
            end
            if (abortAt != 2) begin
                idleInputs();
                expCount = expCount + 16'h0001;
                expPc    = redir ? target : expPc + PC_STEP;
            end
        end
    endtask

    // Fetch a halt word, confirm the sequencer stays parked, then recover by reset.
    task automatic runHalt(input int waits);
        logic [15:0] word;
        word = getWord(expPc);
        fetchPhase(waits, word, 1'b0);
        for (int c = 0; c < 6; c++) begin
            check("halt_halted", halted, 16'h0001);
            check("halt_mem_req", bus.mem_req, 16'h0000);
            check("halt_opcode_valid", bus.opcode_valid, 16'h0000);
            check("halt_count", instrCount, expCount);
            check("halt_instr", bus.instr, word);
            check("halt_pc", pc, expPc);
            bus.mem_ack        = 1'($urandom_range(0, 1));
            bus.mem_rdata      = 16'($urandom);
            bus.issue_ack      = 1'($urandom_range(0, 1));
            bus.redirect_valid = 1'($urandom_range(0, 1));
            bus.redirect_pc    = 16'($urandom);
            tick();
        end
        idleInputs();
        doReset();
    endtask

    initial begin
        logic [15:0] target;
        idleInputs();
        memory[16'h0000] = 16'hC123;
        memory[16'h0002] = 16'hD456;
        doReset();

        // Zero-wait memory, immediate accept
        runInstr(0, 0, 1'b0, 16'h0000, 0);
        runInstr(0, 0, 1'b0, 16'h0000, 0);
        check("count_two", instrCount, 16'h0002);

        // Three wait states, four stall cycles
        runInstr(3, 4, 1'b0, 16'h0000, 0);
        check("count_after_stall", instrCount, 16'h0003);

        // Redirect taken and not taken at 0x0010
        memory[16'h0010] = 16'h5A5A;
        runInstr(0, 0, 1'b1, 16'h0010, 0);
        runInstr(0, 0, 1'b1, 16'h0040, 0);
        check("redirect_addr", bus.mem_addr, 16'h0040);
        runInstr(0, 0, 1'b1, 16'h0010, 0);
        runInstr(1, 1, 1'b0, 16'h0040, 0);
        check("sequential_addr", bus.mem_addr, 16'h0012);

        // PC wrap at 0xFFFE
        runInstr(0, 0, 1'b1, 16'hFFFE, 0);
        runInstr(0, 0, 1'b0, 16'h1234, 0);
        check("pc_wrap_addr", bus.mem_addr, 16'h0000);

        // Instruction counter wrap (preset instead of 65536 issues)
        force dut.instrCountR = 16'hFFFE;
        #1;
        release dut.instrCountR;
        expCount = 16'hFFFE;
        runInstr(0, 0, 1'b0, 16'h0000, 0);
        runInstr(0, 0, 1'b0, 16'h0000, 0);
        check("count_wrap", instrCount, 16'h0000);

        // Reset in the mem_ack cycle, then in the issue_ack cycle
        runInstr(2, 0, 1'b0, 16'h0000, 1);
        runInstr(0, 2, 1'b0, 16'h0000, 0);
        runInstr(0, 1, 1'b1, 16'h0100, 2);
        runInstr(0, 0, 1'b0, 16'h0000, 0);

        // Halt opcode at 0x0006
        memory[16'h0006] = 16'h9000;
        runInstr(0, 0, 1'b1, 16'h0006, 0);
        runHalt(1);
        check("post_halt_addr", bus.mem_addr, RESET_PC);
        memory.delete(16'h0006);

        // Randomised traffic against the model
        repeat (60) begin
            target = 16'($urandom);
            runInstr($urandom_range(0, 3), $urandom_range(0, 3),
                     ($urandom_range(0, 3) == 0), target, 0);
        end
        checkFetch();

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
